// File: rtl/dec_stage_fwd_pkg.sv
// dec_stage_fwd_pkg: shared decode-stage opcodes and reset constants
package dec_stage_fwd_pkg;
    typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_NONE} ext_op_t;
    typedef enum logic [2:0] {CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ, CMP_NV6, CMP_NV7} cmp_op_t;
    typedef enum logic [2:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR} npc_op_t;
    localparam logic [31:0] PC_RST_DEF = 32'h3000;
endpackage

// File: rtl/dec_stage_fwd_if.sv
// dec_stage_fwd_if: decode-stage bus bundle
// master drives fetch/control/write-back/forwarding inputs and receives decode results; slave is the decode stage
interface dec_stage_fwd_if
    import dec_stage_fwd_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NFWD = 2
) ();
    logic [DW-1:0] if_instr, if_pc;
    logic if_valid, stall, flush, use_rs, use_rt;
    ext_op_t ext_op;
    cmp_op_t cmp_op;
    npc_op_t npc_op;
    logic wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data, wb_pc;
    logic [NFWD-1:0] fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0] fwd_addr;
    logic [NFWD*DW-1:0] fwd_data;
    logic id_valid;
    logic [DW-1:0] id_instr, id_pc, rd1, rd2, ext_imm, npc;
    logic br_taken, hazard;
    modport master (
        output if_instr, if_pc, if_valid, stall, flush, use_rs, use_rt, ext_op, cmp_op, npc_op,
               wb_we, wb_addr, wb_data, wb_pc, fwd_valid, fwd_ready, fwd_addr, fwd_data,
        input  id_valid, id_instr, id_pc, rd1, rd2, ext_imm, br_taken, npc, hazard
    );
    modport slave (
        input  if_instr, if_pc, if_valid, stall, flush, use_rs, use_rt, ext_op, cmp_op, npc_op,
               wb_we, wb_addr, wb_data, wb_pc, fwd_valid, fwd_ready, fwd_addr, fwd_data,
        output id_valid, id_instr, id_pc, rd1, rd2, ext_imm, br_taken, npc, hazard
    );
endinterface

// File: rtl/dec_stage_fwd_regfile.sv
// dec_stage_fwd_regfile: NREG x DW register file, 2 read / 1 write, write-through bypass, reg 0 hard zero
// ports: clk, reset, we/waddr/wdata write port, ra1/ra2 read addresses, rd1/rd2 read data
module dec_stage_fwd_regfile #(
    parameter int DW = 32,
    parameter int NREG = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);
    logic [DW-1:0] mem [NREG];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end
    assign rd1 = ra1 == '0 ? '0 : (we && waddr == ra1) ? wdata : mem[ra1];
    assign rd2 = ra2 == '0 ? '0 : (we && waddr == ra2) ? wdata : mem[ra2];
endmodule

// File: rtl/dec_stage_fwd.sv
// dec_stage_fwd: MIPS decode stage with IF/ID register, regfile, N-source forwarding, imm extend, branch and next-PC
// ports: clk, reset (sync, active-high), bus (dec_stage_fwd_if.slave) carrying fetch, control, write-back,
//        forwarding inputs and id_*/rd1/rd2/ext_imm/br_taken/npc/hazard outputs
module dec_stage_fwd
    import dec_stage_fwd_pkg::*;
#(
    parameter int DW = 32,
    parameter int NREG = 32,
    parameter int AW = 5,
    parameter int NFWD = 2,
    parameter logic [DW-1:0] PC_RST = DW'(PC_RST_DEF)
) (
    input logic clk,
    input logic reset,
    dec_stage_fwd_if.slave bus
);
    logic id_valid;
    logic [DW-1:0] id_instr, id_pc;
    logic [AW-1:0] rs, rt;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [DW-1:0] rf1, rf2, rd1, rd2, sext, zext, pc4, npc;
    logic [NFWD:0][DW-1:0] c1, c2;
    logic [NFWD:0] p1, p2;
    logic hazard, live, cmp;
    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];
    assign imm16 = id_instr[15:0];
    assign imm26 = id_instr[25:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc <= PC_RST;
        end else if (bus.flush) begin
            id_valid <= 1'b0;
            id_instr <= '0;
        end else if (!(bus.stall || hazard)) begin
            id_valid <= bus.if_valid;
            id_instr <= bus.if_instr;
            id_pc <= bus.if_pc;
        end
    end
    dec_stage_fwd_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
        .clk(clk), .reset(reset), .we(bus.wb_we), .waddr(bus.wb_addr), .wdata(bus.wb_data),
        .ra1(rs), .ra2(rt), .rd1(rf1), .rd2(rf2)
    );
    // Priority chain built from the oldest source down so index 0 (youngest) wins;
    // p* marks that the winning match is still in flight.
    assign c1[NFWD] = rf1;
    assign c2[NFWD] = rf2;
    assign p1[NFWD] = 1'b0;
    assign p2[NFWD] = 1'b0;
    for (genvar i = 0; i < NFWD; i++) begin : g_fwd
        logic m1, m2;
        assign m1 = bus.fwd_valid[i] && bus.fwd_addr[i*AW +: AW] == rs;
        assign m2 = bus.fwd_valid[i] && bus.fwd_addr[i*AW +: AW] == rt;
        assign c1[i] = m1 ? bus.fwd_data[i*DW +: DW] : c1[i+1];
        assign c2[i] = m2 ? bus.fwd_data[i*DW +: DW] : c2[i+1];
        assign p1[i] = m1 ? !bus.fwd_ready[i] : p1[i+1];
        assign p2[i] = m2 ? !bus.fwd_ready[i] : p2[i+1];
    end
    assign rd1 = rs == '0 ? '0 : c1[0];
    assign rd2 = rt == '0 ? '0 : c2[0];
    assign hazard = id_valid && ((bus.use_rs && rs != '0 && p1[0]) || (bus.use_rt && rt != '0 && p2[0]));
    assign sext = {{(DW-16){imm16[15]}}, imm16};
    assign zext = {{(DW-16){1'b0}}, imm16};
    assign cmp = bus.cmp_op == CMP_EQ  ? rd1 == rd2 :
                 bus.cmp_op == CMP_NE  ? rd1 != rd2 :
                 bus.cmp_op == CMP_LEZ ? rd1[DW-1] || rd1 == '0 :
                 bus.cmp_op == CMP_GTZ ? !rd1[DW-1] && rd1 != '0 :
                 bus.cmp_op == CMP_LTZ ? rd1[DW-1] :
                 bus.cmp_op == CMP_GEZ ? !rd1[DW-1] : 1'b0;
    // No redirect is allowed on a bubble or on operands that are still in flight.
    assign live = id_valid && !hazard;
    assign pc4 = bus.if_pc + DW'(4);
    assign npc = !live ? pc4 :
                 bus.npc_op == NPC_BR ? (cmp ? id_pc + DW'(4) + (sext << 2) : pc4) :
                 bus.npc_op == NPC_J  ? {id_pc[DW-1:DW-4], imm26, 2'b00} :
                 bus.npc_op == NPC_JR ? rd1 : pc4;
    assign bus.id_valid = id_valid;
    assign bus.id_instr = id_instr;
    assign bus.id_pc = id_pc;
    assign bus.rd1 = rd1;
    assign bus.rd2 = rd2;
    assign bus.ext_imm = bus.ext_op == EXT_SIGN ? sext :
                         bus.ext_op == EXT_ZERO ? zext :
                         bus.ext_op == EXT_LUI  ? zext << 16 : '0;
    assign bus.br_taken = live && bus.npc_op == NPC_BR && cmp;
    assign bus.npc = npc;
    assign bus.hazard = hazard;
endmodule
